// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Stall/flush controller for the 6-stage pipeline. Merges stall
//             requests, sequences exception flushes behind outstanding
//             data-bus transactions, counts stall cycles and runs a watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int CNT_W  = 32,
  parameter int WDOG_N = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  logic [31:0]      excp_target,
  input  logic             mem_busy,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             hang
);

  localparam int WD_W = (WDOG_N > 2) ? $clog2(WDOG_N) : 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        latch_tgt;
  logic [31:0] tgt_q;
  logic [WD_W-1:0] wd;
  logic        wd_hit;

  // State register and latched exception target (first exception only).
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      tgt_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (latch_tgt) tgt_q <= excp_target;
    end
  end

  // Next-state and stall/flush/redirect decode.
  always_comb begin
    state_nxt = state;
    stall     = 6'b000000;
    flush     = 1'b0;
    new_pc    = 32'd0;
    latch_tgt = 1'b0;
    case (state)
      RUN: begin
        if (excp_valid) begin
          if (!mem_busy) begin
            // Bus idle: redirect immediately, stall requests are moot.
            flush  = 1'b1;
            new_pc = excp_target;
          end else begin
            // Bus transaction cannot be cancelled: freeze and wait.
            stall     = 6'b111111;
            latch_tgt = 1'b1;
            state_nxt = DRAIN;
          end
        end else if (stallreq_mem) begin
          stall = 6'b011111;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end
      end
      DRAIN: begin
        if (mem_busy) begin
          stall = 6'b111111;
        end else begin
          flush     = 1'b1;
          new_pc    = tgt_q;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall[0] && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // The watchdog fires on the stalled cycle that finds wd at its terminal value.
  assign wd_hit = stall[0] && (wd == WD_W'(WDOG_N - 1));
  assign hang   = wd_hit && !reset;

  // Consecutive-stall watchdog counter.
  always_ff @(posedge clk) begin
    if (reset || !stall[0] || flush || wd_hit) begin
      wd <= '0;
    end else begin
      wd <= wd + WD_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_ctrl
//  Purpose  : Scoreboard bench for pipeline_ctrl with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int CNT_W  = 3;
  localparam int WDOG_N = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stallreq_if = 1'b0;
  logic             stallreq_id = 1'b0;
  logic             stallreq_ex = 1'b0;
  logic             stallreq_mem = 1'b0;
  logic             excp_valid = 1'b0;
  logic [31:0]      excp_target = 32'd0;
  logic             mem_busy = 1'b0;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cycles;
  logic             hang;

  pipeline_ctrl #(.CNT_W(CNT_W), .WDOG_N(WDOG_N)) dut (
    .clk(clk), .reset(reset),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_target(excp_target), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cycles(stall_cycles), .hang(hang)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic [CNT_W-1:0] cnt;
    logic             hang;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  // Monitor: the DUT presents a decoded output every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (stall === e.stall && flush === e.flush && new_pc === e.new_pc &&
          stall_cycles === e.cnt && hang === e.hang) begin
        passed++;
      end else begin
        $display("FAIL %s: got stall=%b flush=%b new_pc=%h cnt=%0d hang=%b, expected stall=%b flush=%b new_pc=%h cnt=%0d hang=%b",
                 e.name, stall, flush, new_pc, stall_cycles, hang,
                 e.stall, e.flush, e.new_pc, e.cnt, e.hang);
      end
    end
  end

  task automatic set_in(input logic [3:0] req, input logic ev, input logic [31:0] tgt,
                        input logic busy);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excp_valid  = ev;
    excp_target = tgt;
    mem_busy    = busy;
  endtask

  task automatic expect_cycle(input string name, input logic [5:0] st, input logic fl,
                              input logic [31:0] pc, input int cnt, input logic hg);
    exp_t e;
    e.name = name; e.stall = st; e.flush = fl; e.new_pc = pc;
    e.cnt = CNT_W'(cnt); e.hang = hg;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic skip_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    set_in(4'b0000, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    skip_cycle();
    skip_cycle();
    reset = 1'b0;

    // Idle after reset
    expect_cycle("reset_idle", 6'b000000, 1'b0, 32'd0, 0, 1'b0);

    // Load-use stall for three cycles, then MEM request overrides
    set_in(4'b0010, 1'b0, 32'd0, 1'b0);
    expect_cycle("id_stall_1", 6'b000111, 1'b0, 32'd0, 0, 1'b0);
    expect_cycle("id_stall_2", 6'b000111, 1'b0, 32'd0, 1, 1'b0);
    expect_cycle("id_stall_3", 6'b000111, 1'b0, 32'd0, 2, 1'b0);
    set_in(4'b1010, 1'b0, 32'd0, 1'b0);
    expect_cycle("mem_over_id", 6'b011111, 1'b0, 32'd0, 3, 1'b0);
    set_in(4'b0101, 1'b0, 32'd0, 1'b0);
    expect_cycle("ex_over_if", 6'b001111, 1'b0, 32'd0, 4, 1'b0);
    set_in(4'b0000, 1'b0, 32'd0, 1'b0);
    expect_cycle("idle_cnt5", 6'b000000, 1'b0, 32'd0, 5, 1'b0);

    // Exception with idle bus: same-cycle flush, stall requests ignored
    set_in(4'b1000, 1'b1, 32'hBFC00380, 1'b0);
    expect_cycle("excp_bus_idle", 6'b000000, 1'b1, 32'hBFC00380, 5, 1'b0);

    // Exception behind a 4-cycle bus transaction; later excp_valid ignored
    set_in(4'b0000, 1'b1, 32'h80000180, 1'b1);
    expect_cycle("drain_enter", 6'b111111, 1'b0, 32'd0, 5, 1'b0);
    set_in(4'b1111, 1'b1, 32'h00001234, 1'b1);
    expect_cycle("drain_2", 6'b111111, 1'b0, 32'd0, 6, 1'b0);
    expect_cycle("drain_3", 6'b111111, 1'b0, 32'd0, 7, 1'b0);
    expect_cycle("drain_4_sat", 6'b111111, 1'b0, 32'd0, 7, 1'b0);
    set_in(4'b0000, 1'b1, 32'h00001234, 1'b0);
    expect_cycle("drain_flush", 6'b000000, 1'b1, 32'h80000180, 7, 1'b0);
    set_in(4'b0000, 1'b0, 32'd0, 1'b0);
    expect_cycle("back_to_run", 6'b000000, 1'b0, 32'd0, 7, 1'b0);

    // Reset in the middle of DRAIN
    set_in(4'b0000, 1'b1, 32'hDEADBEEF, 1'b1);
    expect_cycle("drain_again", 6'b111111, 1'b0, 32'd0, 7, 1'b0);
    set_in(4'b0000, 1'b0, 32'd0, 1'b1);
    reset = 1'b1;
    skip_cycle();
    reset = 1'b0;
    expect_cycle("post_reset_run", 6'b000000, 1'b0, 32'd0, 0, 1'b0);
    set_in(4'b0000, 1'b0, 32'd0, 1'b0);
    expect_cycle("post_reset_nopc", 6'b000000, 1'b0, 32'd0, 0, 1'b0);

    // Watchdog: IF stall held 20 cycles, pulses at stalled cycles 8 and 16
    set_in(4'b0001, 1'b0, 32'd0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      expect_cycle($sformatf("wdog_k%0d", k), 6'b000011, 1'b0, 32'd0,
                   (k - 1 > 7) ? 7 : k - 1, (k == 8 || k == 16));
    end
    set_in(4'b0000, 1'b0, 32'd0, 1'b0);
    expect_cycle("wdog_release", 6'b000000, 1'b0, 32'd0, 7, 1'b0);

    // Every expected response must have been consumed by the monitor
    skip_cycle();
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
